// File: rtl/sram_responder.sv
// sram_responder: memory-side responder that turns a level-held read/write
// request into one access cycle on an asynchronous SRAM (setup, WAIT strobe
// cycles, hold), then returns a single-cycle mem_ack.
// Strobes, bus enable and ack are registered from the next-state decode, so
// every pin comes straight from a flop and cannot glitch.

module sram_responder #(
    parameter int AW   = 16,
    parameter int DW   = 16,
    parameter int WAIT = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          mem_read,
    input  logic          mem_write,
    input  logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_wdata,
    output logic          mem_ack,
    output logic [DW-1:0] mem_rdata,
    output logic [AW-1:0] sram_addr,
    input  logic [DW-1:0] sram_din,
    output logic [DW-1:0] sram_dout,
    output logic          sram_doe,
    output logic          sram_ce_n,
    output logic          sram_oe_n,
    output logic          sram_we_n,
    output logic [2:0]    stateout
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        ACK    = 3'd4
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT - 1);

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            wr_q, wr_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            ce_n_q, ce_n_d;
    logic            oe_n_q, oe_n_d;
    logic            we_n_q, we_n_d;
    logic            doe_q, doe_d;
    logic            ack_q, ack_d;
    logic            access_d;

    // Sequencer: sample the request in IDLE, count strobe cycles, capture read data.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (mem_write || mem_read) begin
                    wr_d    = mem_write;
                    addr_d  = mem_addr;
                    wdata_d = mem_wdata;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = CNT_LOAD;
                state_d = STROBE;
            end
            STROBE: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = HOLD;
                    if (!wr_q) begin
                        rdata_d = sram_din;
                    end
                end
            end
            HOLD: begin
                state_d = ACK;
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pin decode from the state being entered, so the pin flops line up with the state flops.
    always_comb begin
        access_d = (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);
        ce_n_d   = !access_d;
        oe_n_d   = !(access_d && !wr_d);
        we_n_d   = !((state_d == STROBE) && wr_d);
        doe_d    = access_d && wr_d;
        ack_d    = (state_d == ACK);
    end

    // State, latched request and pin registers; reset drops every strobe immediately.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            doe_q   <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
            doe_q   <= doe_d;
            ack_q   <= ack_d;
        end
    end

    assign mem_ack   = ack_q;
    assign mem_rdata = rdata_q;
    assign sram_addr = addr_q;
    assign sram_dout = wdata_q;
    assign sram_doe  = doe_q;
    assign sram_ce_n = ce_n_q;
    assign sram_oe_n = oe_n_q;
    assign sram_we_n = we_n_q;
    assign stateout  = state_q;

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: a WAIT=2 instance with a small SRAM
// model and a WAIT=1 instance for the short-strobe case.

module tb_sram_responder;

    logic        clock;
    logic        reset_n;

    // WAIT=2 instance signals
    logic        mem_read, mem_write;
    logic [15:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata, sram_addr, sram_din, sram_dout;
    logic        sram_doe, sram_ce_n, sram_oe_n, sram_we_n;
    logic [2:0]  stateout;

    // WAIT=1 instance signals
    logic        mem_read_1, mem_write_1;
    logic [15:0] mem_addr_1, mem_wdata_1;
    logic        mem_ack_1;
    logic [15:0] mem_rdata_1, sram_addr_1, sram_din_1, sram_dout_1;
    logic        sram_doe_1, sram_ce_n_1, sram_oe_n_1, sram_we_n_1;
    logic [2:0]  stateout_1;

    int n_checks = 0;
    int n_fail   = 0;

    sram_responder #(.AW(16), .DW(16), .WAIT(2)) dut (
        .clock(clock), .reset(reset_n),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout),
        .sram_doe(sram_doe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n), .stateout(stateout)
    );

    sram_responder #(.AW(16), .DW(16), .WAIT(1)) dut1 (
        .clock(clock), .reset(reset_n),
        .mem_read(mem_read_1), .mem_write(mem_write_1),
        .mem_addr(mem_addr_1), .mem_wdata(mem_wdata_1),
        .mem_ack(mem_ack_1), .mem_rdata(mem_rdata_1),
        .sram_addr(sram_addr_1), .sram_din(sram_din_1), .sram_dout(sram_dout_1),
        .sram_doe(sram_doe_1), .sram_ce_n(sram_ce_n_1), .sram_oe_n(sram_oe_n_1),
        .sram_we_n(sram_we_n_1), .stateout(stateout_1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // SRAM model for the WAIT=2 instance: 256 words, seeded on the first edge
    logic [15:0] mem [0:255];
    logic        seeded = 1'b0;
    assign sram_din = mem[sram_addr[7:0]];

    always @(posedge clock) begin
        if (!seeded) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
            mem[8'h23] <= 16'hBEEF;
            mem[8'h10] <= 16'h1010;
            mem[8'h11] <= 16'h2222;
            seeded <= 1'b1;
        end else if (!sram_we_n && sram_doe) begin
            mem[sram_addr[7:0]] <= sram_dout;
        end
    end

    // Simple capture of the write seen on the WAIT=1 instance's pins
    logic [15:0] w1_addr = 16'h0, w1_data = 16'h0;
    assign sram_din_1 = 16'h5A5A;
    always @(posedge clock) begin
        if (!sram_we_n_1 && sram_doe_1) begin
            w1_addr <= sram_addr_1;
            w1_data <= sram_dout_1;
        end
    end

    // Per-cycle log of the WAIT=2 instance, filled by run_cycles
    logic [31:0] ce_mask, oe_mask, we_mask, doe_mask;
    logic [15:0] addr_log [0:31];
    logic [15:0] dout_log [0:31];
    int          ack_first, ack_second;
    logic [15:0] rdata_first, rdata_second;

    // Call just after a rising edge with the request already driven; cycle 0 is that cycle.
    task automatic run_cycles(input int ncyc, input bit b2b, input logic [15:0] next_addr);
        ce_mask = '0; oe_mask = '0; we_mask = '0; doe_mask = '0;
        ack_first = -1; ack_second = -1;
        rdata_first = '0; rdata_second = '0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clock);
            ce_mask[c]  = ~sram_ce_n;
            oe_mask[c]  = ~sram_oe_n;
            we_mask[c]  = ~sram_we_n;
            doe_mask[c] = sram_doe;
            addr_log[c] = sram_addr;
            dout_log[c] = sram_dout;
            if (mem_ack) begin
                if (ack_first < 0) begin
                    ack_first = c;
                    rdata_first = mem_rdata;
                    if (b2b) mem_addr = next_addr;
                    else begin mem_read = 1'b0; mem_write = 1'b0; end
                end else if (ack_second < 0) begin
                    ack_second = c;
                    rdata_second = mem_rdata;
                    mem_read = 1'b0; mem_write = 1'b0;
                end
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_reset();
        int got;
        reset_n = 1'b0;
        mem_read = 1'b1; mem_write = 1'b0;
        mem_addr = 16'h0123; mem_wdata = 16'h0000;
        mem_read_1 = 1'b0; mem_write_1 = 1'b0;
        mem_addr_1 = 16'h0; mem_wdata_1 = 16'h0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        n_checks++; if (sram_ce_n !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ce_n: got %b want 1", sram_ce_n); end
        n_checks++; if (sram_oe_n !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_oe_n: got %b want 1", sram_oe_n); end
        n_checks++; if (sram_we_n !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_we_n: got %b want 1", sram_we_n); end
        n_checks++; if (sram_doe !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_doe: got %b want 0", sram_doe); end
        n_checks++; if (mem_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ack: got %b want 0", mem_ack); end
        n_checks++; if (mem_rdata !== 16'h0) begin n_fail++; $display("[TB] FAIL reset_rdata: got %h want 0000", mem_rdata); end
        n_checks++; if (sram_addr !== 16'h0) begin n_fail++; $display("[TB] FAIL reset_addr: got %h want 0000", sram_addr); end
        n_checks++; if (stateout !== 3'd0) begin n_fail++; $display("[TB] FAIL reset_state: got %0d want 0", stateout); end
        reset_n = 1'b1;
        #1;
        n_checks++; if (stateout !== 3'd0) begin n_fail++; $display("[TB] FAIL release_idle: got %0d want 0", stateout); end
        @(negedge clock);
        n_checks++; if (stateout !== 3'd1 || sram_ce_n !== 1'b0) begin n_fail++; $display("[TB] FAIL release_setup: got state %0d ce_n %b want 1 0", stateout, sram_ce_n); end
        got = -1;
        for (int c = 2; c < 12; c++) begin
            @(negedge clock);
            if (mem_ack && got < 0) begin got = c; mem_read = 1'b0; end
        end
        n_checks++; if (got !== 5) begin n_fail++; $display("[TB] FAIL release_ack_cycle: got %0d want 5", got); end
        @(posedge clock); #1;
    endtask

    task automatic test_read();
        mem_addr = 16'h0123; mem_read = 1'b1; mem_write = 1'b0;
        run_cycles(8, 1'b0, 16'h0);
        n_checks++; if (ack_first !== 5) begin n_fail++; $display("[TB] FAIL read_ack_cycle: got %0d want 5", ack_first); end
        n_checks++; if (rdata_first !== 16'hBEEF) begin n_fail++; $display("[TB] FAIL read_rdata: got %h want beef", rdata_first); end
        n_checks++; if (oe_mask !== 32'h1E) begin n_fail++; $display("[TB] FAIL read_oe_cycles: got %h want 0000001e", oe_mask); end
        n_checks++; if (we_mask !== 32'h0 || doe_mask !== 32'h0) begin n_fail++; $display("[TB] FAIL read_no_drive: got we %h doe %h want 0 0", we_mask, doe_mask); end
        n_checks++; if (addr_log[1] !== 16'h0123 || addr_log[4] !== 16'h0123) begin n_fail++; $display("[TB] FAIL read_addr: got %h/%h want 0123", addr_log[1], addr_log[4]); end
        n_checks++; if (mem_rdata !== 16'hBEEF) begin n_fail++; $display("[TB] FAIL read_rdata_held: got %h want beef", mem_rdata); end
    endtask

    task automatic test_write();
        mem_addr = 16'h0040; mem_wdata = 16'h1234; mem_write = 1'b1; mem_read = 1'b0;
        run_cycles(8, 1'b0, 16'h0);
        n_checks++; if (ack_first !== 5) begin n_fail++; $display("[TB] FAIL write_ack_cycle: got %0d want 5", ack_first); end
        n_checks++; if (we_mask !== 32'h0C) begin n_fail++; $display("[TB] FAIL write_we_cycles: got %h want 0000000c", we_mask); end
        n_checks++; if (doe_mask !== 32'h1E) begin n_fail++; $display("[TB] FAIL write_doe_cycles: got %h want 0000001e", doe_mask); end
        n_checks++; if (oe_mask !== 32'h0) begin n_fail++; $display("[TB] FAIL write_oe: got %h want 0", oe_mask); end
        n_checks++; if (dout_log[1] !== 16'h1234 || dout_log[4] !== 16'h1234) begin n_fail++; $display("[TB] FAIL write_dout: got %h/%h want 1234", dout_log[1], dout_log[4]); end
        n_checks++; if (mem[8'h40] !== 16'h1234) begin n_fail++; $display("[TB] FAIL write_mem: got %h want 1234", mem[8'h40]); end
    endtask

    task automatic test_both_high();
        mem_addr = 16'h0050; mem_wdata = 16'hA5A5; mem_write = 1'b1; mem_read = 1'b1;
        run_cycles(8, 1'b0, 16'h0);
        n_checks++; if (ack_first !== 5) begin n_fail++; $display("[TB] FAIL both_ack_cycle: got %0d want 5", ack_first); end
        n_checks++; if (oe_mask !== 32'h0) begin n_fail++; $display("[TB] FAIL both_oe: got %h want 0", oe_mask); end
        n_checks++; if (we_mask !== 32'h0C) begin n_fail++; $display("[TB] FAIL both_we_cycles: got %h want 0000000c", we_mask); end
        n_checks++; if (mem[8'h50] !== 16'hA5A5) begin n_fail++; $display("[TB] FAIL both_mem: got %h want a5a5", mem[8'h50]); end
    endtask

    task automatic test_back_to_back();
        mem_addr = 16'h0010; mem_read = 1'b1; mem_write = 1'b0;
        run_cycles(14, 1'b1, 16'h0011);
        n_checks++; if (ack_first !== 5) begin n_fail++; $display("[TB] FAIL b2b_ack1: got %0d want 5", ack_first); end
        n_checks++; if (ack_second !== 11) begin n_fail++; $display("[TB] FAIL b2b_ack2: got %0d want 11", ack_second); end
        n_checks++; if (ce_mask !== 32'h79E) begin n_fail++; $display("[TB] FAIL b2b_ce_cycles: got %h want 0000079e", ce_mask); end
        n_checks++; if (addr_log[7] !== 16'h0011) begin n_fail++; $display("[TB] FAIL b2b_addr2: got %h want 0011", addr_log[7]); end
        n_checks++; if (rdata_first !== 16'h1010 || rdata_second !== 16'h2222) begin n_fail++; $display("[TB] FAIL b2b_rdata: got %h/%h want 1010/2222", rdata_first, rdata_second); end
    endtask

    task automatic test_wait1();
        int ack_c;
        logic [31:0] we1, oe1;
        // Write with both request lines high
        mem_addr_1 = 16'h0007; mem_wdata_1 = 16'h7777; mem_read_1 = 1'b1; mem_write_1 = 1'b1;
        ack_c = -1; we1 = '0; oe1 = '0;
        for (int c = 0; c < 7; c++) begin
            @(negedge clock);
            we1[c] = ~sram_we_n_1;
            oe1[c] = ~sram_oe_n_1;
            if (mem_ack_1 && ack_c < 0) begin ack_c = c; mem_read_1 = 1'b0; mem_write_1 = 1'b0; end
            @(posedge clock); #1;
        end
        n_checks++; if (ack_c !== 4) begin n_fail++; $display("[TB] FAIL w1_write_ack: got %0d want 4", ack_c); end
        n_checks++; if (we1 !== 32'h4) begin n_fail++; $display("[TB] FAIL w1_we_cycles: got %h want 00000004", we1); end
        n_checks++; if (oe1 !== 32'h0) begin n_fail++; $display("[TB] FAIL w1_oe: got %h want 0", oe1); end
        n_checks++; if (w1_addr !== 16'h0007 || w1_data !== 16'h7777) begin n_fail++; $display("[TB] FAIL w1_write_data: got %h@%h want 7777@0007", w1_data, w1_addr); end
        // Read
        mem_addr_1 = 16'h0009; mem_read_1 = 1'b1;
        ack_c = -1;
        for (int c = 0; c < 7; c++) begin
            @(negedge clock);
            if (mem_ack_1 && ack_c < 0) begin
                ack_c = c; mem_read_1 = 1'b0;
                n_checks++; if (mem_rdata_1 !== 16'h5A5A) begin n_fail++; $display("[TB] FAIL w1_rdata: got %h want 5a5a", mem_rdata_1); end
            end
            @(posedge clock); #1;
        end
        n_checks++; if (ack_c !== 4) begin n_fail++; $display("[TB] FAIL w1_read_ack: got %0d want 4", ack_c); end
    endtask

    task automatic test_reset_mid();
        int got;
        logic ack_seen;
        mem_addr = 16'h0050; mem_read = 1'b1; mem_write = 1'b0;
        repeat (2) begin @(posedge clock); end
        @(negedge clock);
        n_checks++; if (stateout !== 3'd2) begin n_fail++; $display("[TB] FAIL mid_in_strobe: got %0d want 2", stateout); end
        reset_n = 1'b0;
        #1;
        n_checks++; if (sram_ce_n !== 1'b1 || sram_oe_n !== 1'b1 || sram_we_n !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_strobes: got ce %b oe %b we %b want 1 1 1", sram_ce_n, sram_oe_n, sram_we_n); end
        n_checks++; if (mem_rdata !== 16'h0 || stateout !== 3'd0) begin n_fail++; $display("[TB] FAIL mid_cleared: got rdata %h state %0d want 0000 0", mem_rdata, stateout); end
        ack_seen = 1'b0;
        repeat (3) begin @(negedge clock); if (mem_ack) ack_seen = 1'b1; end
        n_checks++; if (ack_seen !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_no_ack: got %b want 0", ack_seen); end
        reset_n = 1'b1;
        got = -1;
        for (int c = 1; c < 10; c++) begin
            @(negedge clock);
            if (mem_ack && got < 0) begin
                got = c; mem_read = 1'b0;
                n_checks++; if (mem_rdata !== 16'hA5A5) begin n_fail++; $display("[TB] FAIL mid_fresh_rdata: got %h want a5a5", mem_rdata); end
            end
        end
        n_checks++; if (got !== 5) begin n_fail++; $display("[TB] FAIL mid_fresh_ack: got %0d want 5", got); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_both_high();
        test_back_to_back();
        test_wait1();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule
